// File: rtl/matrix_pkg.sv
// Shared constants and types for the element-serial 3x3 matrix arithmetic blocks.
// SATURATE_EN (in element_add) selects clamping instead of wrap on signed overflow.
package matrix_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 9;
  localparam int unsigned IW = $clog2(N);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {
    LOAD,
    DRAIN
  } state_e;

endpackage

// File: rtl/element_add.sv
// W-bit two's-complement adder with signed-overflow flag.
// With SATURATE_EN defined the sum clamps to SAT_MAX/SAT_MIN on overflow; otherwise it wraps.
module element_add
  import matrix_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef SATURATE_EN
  // Overflow direction follows the common operand sign.
  assign sum = ovf ? (a[W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/matrix_adder_seq.sv
// Sequential 3x3 element-wise adder: loads N element pairs, buffers the sums, then streams them.
// Overflow behaviour is selected by SATURATE_EN inside element_add.
module matrix_adder_seq
  import matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          ovf
);

  state_e        state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [IW-1:0] out_cnt_q, out_cnt_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_q [N];

  logic [W-1:0]  sum;
  logic          sum_ovf;
  logic          in_acc;
  logic          out_xfer;

  element_add u_add (
    .a   (in_a),
    .b   (in_b),
    .sum (sum),
    .ovf (sum_ovf)
  );

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign in_acc    = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      LOAD: begin
        if (in_acc) begin
          ovf_d = ovf_q | sum_ovf;
          if (in_cnt_q == IW'(N - 1)) begin
            in_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (out_cnt_q == IW'(N - 1)) begin
            out_cnt_d = '0;
            ovf_d     = 1'b0;
            state_d   = LOAD;
          end else begin
            out_cnt_d = out_cnt_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem_q[in_cnt_q] <= sum;
    end
  end

  assign out_data = out_valid ? mem_q[out_cnt_q] : '0;
  assign out_idx  = out_cnt_q;
  assign out_last = out_valid && (out_cnt_q == IW'(N - 1));
  assign ovf      = ovf_q;

endmodule
